block_mover: RTL
================

Name: block_mover

Overview:
- Responder side of the game FSM's piece-control interface.
- Accepts new_block/move commands from the game FSM and steps a 2x2 piece over a COLS x ROWS grid using frame-rate gravity and the LEFT/RIGHT/DOWN buttons.
- Keeps its own landed-cell occupancy map and reports done (piece landed) and game_over (spawn blocked).
- Produces frame_pixel, the piece/stack overlay that the FSM ORs with the board art.

Parameters:
COLS, 10, grid width in cells
ROWS, 20, grid height in cells
CELL, 16, cell size in pixels (power of two)
SPAWN_COL, 4, left column of a newly spawned piece
GRAVITY_FRAMES, 30, frames per automatic one-row drop
PIECE_COLOR, 8'h1C, pixel value for the falling piece
STACK_COLOR, 8'hE0, pixel value for landed cells

Ports:
vclk  in  1  pixel clock; everything is sequential on posedge
rst  in  1  reset, asynchronous, active-high
frame  in  1  one-vclk pulse per video frame
LEFT  in  1  button level, move left
RIGHT  in  1  button level, move right
DOWN  in  1  button level, soft drop
move  in  1  FSM permits motion (level)
new_block  in  1  FSM requests a new piece (level)
vsync  in  1  VGA vsync, active-low pulse
hcount  in  11  current pixel x
vcount  in  10  current pixel y
x_in  in  11  grid origin x in pixels (FSM drives 259)
y_in  in  10  grid origin y in pixels (FSM drives 17)
done  out  1  one-cycle pulse: piece landed
game_over  out  1  sticky: spawn collided
frame_pixel  out  8  overlay pixel, registered

Behaviour:
- One clock, vclk. Reset is asynchronous and active-high on rst.
- Reset values:
  - state=IDLE; col=SPAWN_COL, row=0 (live and display copies)
  - occupancy all 0; gravity counter 0; button history 0
  - done=0, game_over=0, frame_pixel=8'h00
- A piece occupies (row,row+1) x (col,col+1).
  - col range 0..COLS-2; row range 0..ROWS-2.
  - col/row are unsigned and never wrap; bounds are checked before any update.
- States:
  - IDLE: on new_block=1, latch x_in/y_in as origin, set col=SPAWN_COL, row=0, gravity counter=0 -> SPAWN.
  - SPAWN: one cycle. If any of the 4 spawn cells is occupied -> OVER, game_over=1. Else -> WAIT.
  - WAIT: -> FALL when move=1.
  - FALL:
    - If move=0, hold all state and ignore frame.
    - On each frame pulse:
      - Press = button level 1 now and 0 at the previous frame pulse; history updates every frame.
      - Horizontal: LEFT press has priority over RIGHT. Shift col by ±1 only if inside bounds and both target cells are free.
      - Drop request: DOWN press, or gravity counter == GRAVITY_FRAMES-1. A drop request resets the counter; otherwise the counter increments.
      - Drop check uses the post-horizontal col.
      - Drop succeeds if row<ROWS-2 and both cells below are free: row+1.
      - Drop blocked -> LAND.
  - LAND: write the 4 piece cells to occupancy, pulse done=1 for exactly this one cycle -> IDLE.
  - OVER: terminal until rst; game_over stays 1; frame and buttons are ignored.
- new_block is ignored outside IDLE. done is never asserted in any other state.
- Display copy:
  - col/row/show_piece are copied to display registers only on cycles with vsync=0, so a frame never tears.
  - show_piece=1 in WAIT/FALL.
- Pixel path, registered, latency 1 vclk:
  - Inside grid means origin_x <= hcount < origin_x+COLS*CELL and origin_y <= vcount < origin_y+ROWS*CELL.
  - Cell index = (hcount-origin_x)/CELL, (vcount-origin_y)/CELL, computed as a shift.
  - Output: PIECE_COLOR if show_piece and the cell is in the display piece; else STACK_COLOR if the cell is occupied; else 8'h00.
  - Outside the grid: 8'h00.
- Line clearing is not done in this block.
- Reset mid-operation: all state clears immediately, occupancy included.

Test Plan:
- Reset, then new_block=1 with x_in=259, y_in=17, then move=1 -> state FALL. With hcount=323, vcount=17, frame_pixel=8'h1C one vclk later. At hcount=355, frame_pixel=8'h00.
- FALL with no buttons, 30 frame pulses -> row 0->1 exactly on the 30th pulse. The piece now covers vcount 33..64; done stays 0.
- LEFT held high for 10 frames -> col decrements once only (edge detect). Press LEFT 5 separate times from col 4 -> col stops at 0. Press LEFT+RIGHT together -> LEFT wins.
- Soft-drop to row 18, then one more drop request -> LAND: done high exactly 1 cycle. Cells (18..19,4..5) are then drawn 8'hE0 and state is IDLE.
- Fill cells (0..1,4..5) by landing a piece there, then issue new_block -> game_over=1 two cycles later and stays 1. No done pulse; frame/button stimulus changes nothing.
- Assert rst mid-FALL at row 7 -> game_over=0, done=0, frame_pixel=0 immediately; grid cleared; the next spawn lands at row 18.

Source files
------------

// File: rtl/block_mover.sv
// block_mover: responder side of the game FSM's piece-control interface.
// Steps a 2x2 piece over a COLS x ROWS grid with frame-rate gravity and
// LEFT/RIGHT/DOWN buttons, keeps the landed-cell occupancy map, and draws
// the piece/stack overlay that the FSM ORs with the board art.
module block_mover #(
   parameter int          COLS           = 10,
   parameter int          ROWS           = 20,
   parameter int          CELL           = 16,
   parameter int          SPAWN_COL      = 4,
   parameter int          GRAVITY_FRAMES = 30,
   parameter logic [7:0]  PIECE_COLOR    = 8'h1C,
   parameter logic [7:0]  STACK_COLOR    = 8'hE0
) (
   input  logic        vclk,
   input  logic        rst,
   input  logic        frame,
   input  logic        LEFT,
   input  logic        RIGHT,
   input  logic        DOWN,
   input  logic        move,
   input  logic        new_block,
   input  logic        vsync,
   input  logic [10:0] hcount,
   input  logic [9:0]  vcount,
   input  logic [10:0] x_in,
   input  logic [9:0]  y_in,
   output logic        done,
   output logic        game_over,
   output logic [7:0]  frame_pixel
);

   localparam int CW  = $clog2(COLS);
   localparam int RW  = $clog2(ROWS);
   localparam int GW  = $clog2(GRAVITY_FRAMES);
   localparam int CSH = $clog2(CELL);

   localparam logic [CW-1:0] COL_MAX   = CW'(COLS - 2);
   localparam logic [RW-1:0] ROW_MAX   = RW'(ROWS - 2);
   localparam logic [CW-1:0] SPAWN_C0  = CW'(SPAWN_COL);
   localparam logic [CW-1:0] SPAWN_C1  = CW'(SPAWN_COL + 1);
   localparam logic [GW-1:0] GRAV_LAST = GW'(GRAVITY_FRAMES - 1);
   localparam logic [11:0]   GRID_W    = 12'(COLS * CELL);
   localparam logic [10:0]   GRID_H    = 11'(ROWS * CELL);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_SPAWN = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_FALL  = 3'd3;
   localparam logic [2:0] S_LAND  = 3'd4;
   localparam logic [2:0] S_OVER  = 3'd5;

   logic [2:0]               state;
   logic [CW-1:0]            col;
   logic [RW-1:0]            row;
   logic [10:0]              org_x;
   logic [9:0]               org_y;
   logic [GW-1:0]            grav_cnt;
   logic [2:0]               btn_hist;   // {DOWN, RIGHT, LEFT} at the previous frame
   logic [ROWS-1:0][COLS-1:0] occ;

   logic [CW-1:0]            disp_col;
   logic [RW-1:0]            disp_row;
   logic                     disp_show;

   // Motion decode helpers; neighbour indices are clamped so they never leave the grid.
   logic                     press_l, press_r, press_d;
   logic [CW-1:0]            col_m1, col_p1, col_p2, h_col, h_col_p1;
   logic [RW-1:0]            row_p1, row_p2;
   logic                     can_left, can_right, can_drop, drop_req, spawn_blocked;

   assign press_l  = LEFT  & ~btn_hist[0];
   assign press_r  = RIGHT & ~btn_hist[1];
   assign press_d  = DOWN  & ~btn_hist[2];

   assign col_m1   = (col == '0)     ? col : col - CW'(1);
   assign col_p1   = col + CW'(1);
   assign col_p2   = (col < COL_MAX) ? col + CW'(2) : col;
   assign row_p1   = row + RW'(1);
   assign row_p2   = (row < ROW_MAX) ? row + RW'(2) : row;

   assign can_left  = (col != '0) && !occ[row][col_m1] && !occ[row_p1][col_m1];
   assign can_right = (col < COL_MAX) && !occ[row][col_p2] && !occ[row_p1][col_p2];

   // Horizontal step: a LEFT press owns the frame even when it is blocked.
   always_comb begin
      // NOTE: default assignment first so every path drives h_col; no latch is inferred.
      h_col = col;
      if (press_l) begin
         if (can_left) h_col = col - CW'(1);
      end else if (press_r && can_right) begin
         h_col = col + CW'(1);
      end
   end

   assign h_col_p1 = h_col + CW'(1);
   assign can_drop = (row < ROW_MAX) && !occ[row_p2][h_col] && !occ[row_p2][h_col_p1];
   assign drop_req = press_d || (grav_cnt == GRAV_LAST);

   assign spawn_blocked = occ[0][SPAWN_C0] | occ[0][SPAWN_C1] |
                          occ[1][SPAWN_C0] | occ[1][SPAWN_C1];

   // Piece-control FSM, gravity, button history and occupancy map.
   always_ff @(posedge vclk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         col       <= SPAWN_C0;
         row       <= '0;
         org_x     <= '0;
         org_y     <= '0;
         grav_cnt  <= '0;
         btn_hist  <= '0;
         // NOTE: occupancy is a flop array rather than a RAM, so reset clears it in one shot.
         occ       <= '0;
         done      <= 1'b0;
         game_over <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments throughout; every branch reads the pre-edge values.
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (new_block) begin
                  org_x    <= x_in;
                  org_y    <= y_in;
                  col      <= SPAWN_C0;
                  row      <= '0;
                  grav_cnt <= '0;
                  state    <= S_SPAWN;
               end
            end
            S_SPAWN: begin
               if (spawn_blocked) begin
                  state     <= S_OVER;
                  game_over <= 1'b1;
               end else begin
                  state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (move) state <= S_FALL;
            end
            S_FALL: begin
               if (move && frame) begin
                  btn_hist <= {DOWN, RIGHT, LEFT};
                  col      <= h_col;
                  if (drop_req) begin
                     grav_cnt <= '0;
                     if (can_drop) begin
                        row <= row + RW'(1);
                     end else begin
                        state <= S_LAND;
                        done  <= 1'b1;
                     end
                  end else begin
                     grav_cnt <= grav_cnt + GW'(1);
                  end
               end
            end
            S_LAND: begin
               occ[row][col]       <= 1'b1;
               occ[row][col_p1]    <= 1'b1;
               occ[row_p1][col]    <= 1'b1;
               occ[row_p1][col_p1] <= 1'b1;
               state               <= S_IDLE;
            end
            S_OVER: begin
               state <= S_OVER;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   // Display copy of the piece, refreshed only while vsync is low so a frame never tears.
   always_ff @(posedge vclk or posedge rst) begin
      if (rst) begin
         disp_col  <= SPAWN_C0;
         disp_row  <= '0;
         disp_show <= 1'b0;
      end else if (!vsync) begin
         disp_col  <= col;
         disp_row  <= row;
         disp_show <= (state == S_WAIT) || (state == S_FALL);
      end
   end

   // Pixel decode: grid hit test, cell index by shift, then piece over stack over background.
   logic [10:0]   rel_x;
   logic [9:0]    rel_y;
   logic [CW-1:0] cell_x;
   logic [RW-1:0] cell_y;
   logic          in_grid, in_piece;
   logic [7:0]    pixel_next;

   assign rel_x  = hcount - org_x;
   assign rel_y  = vcount - org_y;
   assign cell_x = CW'(rel_x >> CSH);
   assign cell_y = RW'(rel_y >> CSH);

   assign in_grid = ({1'b0, hcount} >= {1'b0, org_x}) &&
                    ({1'b0, hcount} <  {1'b0, org_x} + GRID_W) &&
                    ({1'b0, vcount} >= {1'b0, org_y}) &&
                    ({1'b0, vcount} <  {1'b0, org_y} + GRID_H);

   assign in_piece = disp_show &&
                     ((cell_x == disp_col) || (cell_x == disp_col + CW'(1))) &&
                     ((cell_y == disp_row) || (cell_y == disp_row + RW'(1)));

   // Overlay colour select for the current pixel.
   always_comb begin
      pixel_next = 8'h00;
      if (in_grid) begin
         if (in_piece)                 pixel_next = PIECE_COLOR;
         else if (occ[cell_y][cell_x]) pixel_next = STACK_COLOR;
      end
   end

   // Register the overlay pixel (one vclk of latency).
   always_ff @(posedge vclk or posedge rst) begin
      if (rst) frame_pixel <= 8'h00;
      else     frame_pixel <= pixel_next;
   end

endmodule
